// File: rtl/macc_sched.sv
// Compute scheduler for the matrix accelerator: walks i/j/k over NxN operands,
// issuing A/B reads and accumulating each dot product before writing it into C.
module macc_sched #(
  parameter int ADDR_MSB = 11,
  parameter int ROW_LOG2 = 6,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_L,
  input  logic              start,
  input  logic              abort,
  input  logic [6:0]        dim,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_MSB:0] a_addr,
  output logic [ADDR_MSB:0] b_addr,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_MSB:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic              c_we
);

  localparam int AW   = ADDR_MSB + 1;
  localparam int CW   = ROW_LOG2;
  localparam int NMAX = 1 << ROW_LOG2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d, nm1_q, nm1_d;
  logic [AW-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [DATA_W-1:0] acc_q, acc_d, c_wdata_q, c_wdata_d, prod;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, c_we_q, c_we_d;
  logic              rvld_q, rvld_d, first_q, first_d;
  logic [CW-1:0]     kn, jn, in_;

  // Row-major word address: row in the upper bits, column in the lower.
  function automatic logic [AW-1:0] rc(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return AW'({r, c});
  endfunction

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    nm1_d     = nm1_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    c_we_d    = 1'b0;
    rvld_d    = 1'b0;
    first_d   = 1'b0;
    kn        = k_q + CW'(1);
    jn        = j_q + CW'(1);
    in_       = i_q + CW'(1);
    // Low DATA_W bits of the product are identical for signed and unsigned.
    prod      = a_rdata * b_rdata;

    if (rvld_q) acc_d = first_q ? prod : acc_q + prod;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (dim != 7'd0 && int'(dim) <= NMAX) begin
            nm1_d    = CW'(dim - 7'd1);
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            a_addr_d = rc('0, '0);
            b_addr_d = rc('0, '0);
            state_d  = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        rvld_d  = 1'b1;
        first_d = (k_q == '0);
        if (k_q == nm1_q) begin
          state_d = DRAIN;
        end else begin
          k_d      = kn;
          a_addr_d = rc(i_q, kn);
          b_addr_d = rc(kn, j_q);
        end
      end
      DRAIN: begin
        // acc_d already includes the final product returning this cycle.
        state_d   = WRITE;
        c_we_d    = 1'b1;
        c_addr_d  = rc(i_q, j_q);
        c_wdata_d = acc_d;
      end
      WRITE: begin
        k_d = '0;
        if (j_q == nm1_q) begin
          j_d = '0;
          if (i_q == nm1_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            i_d      = in_;
            a_addr_d = rc(in_, '0);
            b_addr_d = rc('0, '0);
            state_d  = ISSUE;
          end
        end else begin
          j_d      = jn;
          a_addr_d = rc(i_q, '0);
          b_addr_d = rc('0, jn);
          state_d  = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort pre-empts everything, including a pending write.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      c_we_d    = 1'b0;
      done_d    = 1'b0;
      rvld_d    = 1'b0;
      a_addr_d  = a_addr_q;
      b_addr_d  = b_addr_q;
      c_addr_d  = c_addr_q;
      c_wdata_d = c_wdata_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      nm1_q     <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      c_we_q    <= 1'b0;
      rvld_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      nm1_q     <= nm1_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      c_we_q    <= c_we_d;
      rvld_q    <= rvld_d;
      first_q   <= first_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign a_addr  = a_addr_q;
  assign b_addr  = b_addr_q;
  assign c_addr  = c_addr_q;
  assign c_wdata = c_wdata_q;
  assign c_we    = c_we_q;

endmodule

// File: doc/macc_sched.md
Name: macc_sched

Overview:
- Compute scheduler for the matrix accelerator: sequences reads of matrix RAMs A and B and writes results into matrix RAM C, computing C = A x B for square NxN matrices, N = 1..64.
- Sits beside the per-matrix RAM controllers inside macc.
- While busy it owns the A/B read ports and the C write port. The top level muxes host access against busy.

Parameters:
- ADDR_MSB, 11, MSB of RAM word address; address = row*64 + col.
- ROW_LOG2, 6, log2 of row stride (64 words per row).
- DATA_W, 32, operand/result width.

Ports:
- CLK  in  1  clock
- RST_L  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a multiply
- abort  in  1  synchronous cancel of a running multiply
- dim  in  7  matrix dimension N; valid 1..64, sampled on accepted start
- busy  out  1  high from cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse when start is rejected for invalid dim
- a_addr  out  ADDR_MSB+1  A read address
- b_addr  out  ADDR_MSB+1  B read address
- a_rdata  in  DATA_W  A read data, valid 1 cycle after a_addr
- b_rdata  in  DATA_W  B read data, valid 1 cycle after b_addr
- c_addr  out  ADDR_MSB+1  C write address
- c_wdata  out  DATA_W  C write data
- c_we  out  1  C write enable, one cycle per element

Behaviour:
Reset (async, RST_L=0):
- State is IDLE.
- busy, done, err, c_we are 0.
- a_addr, b_addr, c_addr, c_wdata, accumulator and all counters are 0.
- Outputs go to these values immediately, with no clock needed.

States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE:
  - start=1 with dim in 1..64: latch N, clear i, j, k; go to ISSUE.
  - start=1 with dim=0 or dim>64: stay IDLE, pulse err next cycle.
- ISSUE, one cycle per k = 0..N-1:
  - a_addr = i*64+k, b_addr = k*64+j.
  - At k=N-1, go to DRAIN.
- DRAIN: one cycle; the last product is accumulated. Go to WRITE.
- WRITE: one cycle.
  - c_we=1, c_addr = i*64+j, c_wdata = accumulator.
  - Advance j. On j wrap (j=N-1), j=0 and advance i.
  - If i=N-1 and j=N-1, go to IDLE and pulse done in the cycle IDLE is entered; else go to ISSUE with k=0.

Datapath:
- A registered read-valid bit and a first-flag follow each ISSUE cycle.
- In the cycle data returns: acc <= first ? a*b : acc + a*b.
- Product and sum are signed two's complement, truncated to the low DATA_W bits (wraps modulo 2^32, no saturation, no overflow flag).

Timing:
- Each element takes N+2 cycles.
- Whole matrix takes N*N*(N+2) cycles from the first ISSUE cycle to the last WRITE.
- done is asserted exactly one cycle after the last c_we.

Boundary conditions:
- start while busy: ignored; no effect on dim, state or counters.
- abort=1 in any non-IDLE state: next state IDLE.
  - c_we is 0 in that cycle if the abort cycle would have been WRITE; abort wins over WRITE.
  - No done. busy drops next cycle.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: start is ignored.
- RST_L low mid-operation: immediate return to IDLE per reset values. C contents already written are not restored.
- N=1: one ISSUE, one DRAIN, one WRITE; done on cycle 4 after start is accepted.
- a_addr/b_addr hold their last value outside ISSUE. c_addr/c_wdata hold outside WRITE. Only c_we qualifies a write.

Test Plan:
- N=1, A[0]=3, B[0]=-5, start -> single c_we at c_addr=0 with c_wdata=0xFFFFFFF1; done 1 cycle later; total 3 active cycles.
- N=2, A=[1 2;3 4], B=[5 6;7 8] -> writes in order addr 0=19, 1=22, 64=43, 65=50; 16 cycles ISSUE..last WRITE; done once.
- N=64, A=identity, B[r][c]=r*64+c -> C equals B at every address; busy high for 64*64*66 cycles.
- dim=0 and dim=65 start -> err pulse, busy stays 0, no c_we; then valid start with dim=2 runs normally.
- Overflow: N=2, all A and B entries 0x80000000 -> every c_wdata = 0x00000000 (wrap, no saturation).
- Abort during 3rd element's ISSUE (N=2) -> exactly 2 c_we observed, no done, busy low next cycle. Repeat with RST_L pulsed mid-DRAIN -> all outputs 0 asynchronously; a following start completes correctly.
